// File: rtl/wrr_arb_pkg.sv
// Shared types and default sizing for the weighted round-robin lock arbiter.
package wrr_arb_pkg;

    typedef enum logic {
        StIdle,
        StHold
    } arb_state_e;

    localparam int unsigned DefaultN  = 16;
    localparam int unsigned DefaultWw = 4;

endpackage

// File: rtl/wrr_rr_pick.sv
// Rotating first-one search: first set request at or above ptr_i, wrapping modulo N.
module wrr_rr_pick
    import wrr_arb_pkg::*;
#(
    parameter int unsigned N  = DefaultN,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic          found_o,
    output logic [IW-1:0] winner_o
);

    logic [IW-1:0] idx;

    // Scan N positions starting at the pointer and keep the first hit.
    always_comb begin
        found_o  = 1'b0;
        winner_o = '0;
        idx      = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = IW'((32'(ptr_i) + i) % N);
            if (!found_o && req_i[idx]) begin
                found_o  = 1'b1;
                winner_o = idx;
            end
        end
    end

endmodule

// File: rtl/wrr_lock_arbiter.sv
// Weighted round-robin arbiter with per-requester burst lock and registered grant.
module wrr_lock_arbiter
    import wrr_arb_pkg::*;
#(
    parameter int unsigned N  = DefaultN,
    parameter int unsigned WW = DefaultWw,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    lock,
    input  logic [N*WW-1:0] weight,
    output logic [N-1:0]    gnt,
    output logic [IW-1:0]   gnt_id,
    output logic            gnt_valid
);

    arb_state_e    state_q;
    logic [WW-1:0] cnt_q;
    logic [IW-1:0] ptr_q;
    logic [N-1:0]  gnt_q;
    logic [IW-1:0] gnt_id_q;
    logic          gnt_valid_q;

    logic [WW-1:0] holder_wt;
    logic [WW:0]   eff_wt;
    logic [WW:0]   cnt_inc;
    logic          keep_lock;
    logic          keep_quota;
    logic [IW-1:0] search_ptr;
    logic          found;
    logic [IW-1:0] winner;
    logic [N-1:0]  win_onehot;

    function automatic logic [IW-1:0] inc_mod(input logic [IW-1:0] x);
        return (x == IW'(N - 1)) ? '0 : x + 1'b1;
    endfunction

    // Keep/release decision for the current holder; gnt_id_q doubles as the holder index.
    always_comb begin
        holder_wt  = weight[gnt_id_q*WW +: WW];
        // Zero weight still grants one cycle; the extra bit keeps cnt+1 from wrapping.
        eff_wt     = (holder_wt == '0) ? (WW+1)'(1) : {1'b0, holder_wt};
        cnt_inc    = {1'b0, cnt_q} + 1'b1;
        keep_lock  = (state_q == StHold) && req[gnt_id_q] && lock[gnt_id_q];
        keep_quota = (state_q == StHold) && req[gnt_id_q] && !lock[gnt_id_q] &&
                     (cnt_inc < eff_wt);
        search_ptr = (state_q == StHold) ? inc_mod(gnt_id_q) : ptr_q;
    end

    wrr_rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req_i    (req),
        .ptr_i    (search_ptr),
        .found_o  (found),
        .winner_o (winner)
    );

    // One-hot image of the search winner.
    always_comb begin
        win_onehot         = '0;
        win_onehot[winner] = 1'b1;
    end

    // FSM, credit counter, pointer and registered grant outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            ptr_q       <= '0;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (found) begin
                        state_q     <= StHold;
                        cnt_q       <= '0;
                        ptr_q       <= inc_mod(winner);
                        gnt_q       <= win_onehot;
                        gnt_id_q    <= winner;
                        gnt_valid_q <= 1'b1;
                    end
                end
                StHold: begin
                    if (keep_lock) begin
                        // Locked cycles consume no quota.
                        cnt_q <= cnt_q;
                    end else if (keep_quota) begin
                        cnt_q <= cnt_inc[WW-1:0];
                    end else if (found) begin
                        // May re-select the same holder when it is the only requester.
                        cnt_q       <= '0;
                        ptr_q       <= inc_mod(winner);
                        gnt_q       <= win_onehot;
                        gnt_id_q    <= winner;
                        gnt_valid_q <= 1'b1;
                    end else begin
                        state_q     <= StIdle;
                        gnt_q       <= '0;
                        gnt_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    gnt_q       <= '0;
                    gnt_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = gnt_valid_q;

endmodule

// File: doc/wrr_lock_arbiter.md
WRR_LOCK_ARBITER -- requirements
Module: wrr_lock_arbiter

Interface
REQ-001 Parameter: N, 16, number of requesters, legal range 2..32.
REQ-002 Parameter: WW, 4, width of each per-requester weight field.
REQ-003 Parameter: IW, $clog2(N), width of the grant index.
REQ-004 Clock and reset: one clock; reset is synchronous and active-high. Port names are clk and rst.
REQ-005 Port: clk  input  1  rising-edge clock.
REQ-006 Port: rst  input  1  synchronous active-high reset.
REQ-007 Port: req  input  N  per-requester request level.
REQ-008 Port: lock  input  N  per-requester burst lock; sampled only for the current holder.
REQ-009 Port: weight  input  N*WW  per-requester consecutive-grant quota; field i is bits [i*WW +: WW]; quasi-static.
REQ-010 Port: gnt  output  N  registered one-hot grant, or all-zero.
REQ-011 Port: gnt_id  output  IW  binary index of the gnt bit; holds its last value when gnt is zero.
REQ-012 Port: gnt_valid  output  1  high when and only when gnt is nonzero.

Function
REQ-013 Grant latency: gnt, gnt_id and gnt_valid are registered and reflect req/lock sampled at the previous rising edge (1-cycle latency).
REQ-014 FSM state IDLE: no holder, gnt=0.
REQ-015 FSM state HOLD: holder h owns gnt; credit counter cnt (WW bits) counts grants issued to h.
REQ-016 IDLE transition: if req=0, stay in IDLE; otherwise go to HOLD with winner w from the rotating search, cnt=0.
REQ-017 Rotating search: scan from pointer ptr upward modulo N and take the first requester whose req bit is set.
REQ-018 HOLD keep condition, part 1 (lock): req[h]=1 and lock[h]=1 keeps gnt on h; cnt does not change (locked cycles consume no quota).
REQ-019 HOLD keep condition, part 2 (quota): req[h]=1, lock[h]=0 and cnt+1 < eff_weight(h) keeps gnt on h and increments cnt.
REQ-020 HOLD release: in every other case, run the rotating search from ptr=(h+1) mod N, excluding nothing; a new winner w gets cnt=0.
REQ-021 HOLD with no requests: if req=0 on release, go to IDLE with gnt=0.
REQ-022 Pointer update: ptr updates to (w+1) mod N only on a new win, never on a keep or in IDLE.
REQ-023 Effective weight: eff_weight(i) = max(weight[i], 1); weight 0 behaves as weight 1.
REQ-024 Counter width: cnt never wraps; the comparison uses WW+1-bit arithmetic.
REQ-025 Self re-win: if h releases on quota and is the only requester, h re-wins, ptr becomes (h+1) mod N, and cnt resets to 0; gnt_valid stays high with no bubble.
REQ-026 Holder drops req: the holder dropping req while lock is high releases normally; lock without req is ignored.
REQ-027 Fairness: with lock always 0, any continuously requesting i is granted within sum over j≠i of eff_weight(j) cycles plus 1.
REQ-028 Weight changes: a weight change takes effect at the next comparison; correctness is not required if weight changes while cnt ≥ the new weight, but the arbiter must release within one cycle.
REQ-029 Pointer wrap: index N-1 wraps to 0 in both search and ptr update.

Reset
REQ-030 rst=1 at a rising edge forces state=IDLE, gnt=0, gnt_id=0, gnt_valid=0, ptr=0 and cnt=0, overriding all other inputs.
REQ-031 Reset mid-burst (locked or not) abandons the holder; the first post-reset grant is searched from ptr=0.
REQ-032 The design has no asynchronous reset path.

Structure
REQ-033 Package wrr_arb_pkg holds the state enum (IDLE, HOLD) and the default N and WW localparams.
REQ-034 The rotating first-one search is sub-module wrr_rr_pick: combinational, inputs req and ptr, outputs found and winner index.
REQ-035 All state lives in a single clocked process in wrr_lock_arbiter.

Verification
REQ-036 Reset then req=16'h0005, all weights 1, lock 0: gnt alternates 0x0001, 0x0004, 0x0001, with gnt_valid=1 from the second cycle after reset release.
REQ-037 Weight[3]=3, weight[5]=1, req bits 3 and 5 held: gnt pattern is 3,3,3,5,3,3,3,5.
REQ-038 Holder 2 granted, lock[2]=1 for 10 cycles with req[7] set: gnt stays 0x0004 for 10 cycles; index 7 is granted in the cycle after lock drops (weight 1).
REQ-039 Only req[15] asserted with weight 2: gnt_valid stays continuously high and ptr wraps to 0 on each re-win.
REQ-040 rst pulsed during an active burst on requester 9: the outputs are zero in the cycle after reset; with req=all-ones the first grant goes to index 0.
REQ-041 Random req/lock, N=5, WW=2 build: assertions hold that gnt is one-hot-or-zero, gnt_id matches gnt, and the REQ-027 starvation bound is never exceeded.
